shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift unit for the MIPS ALU. Executes SLL/SRL/SRA/ROTR with a
//  narrow per-cycle step shifter instead of a full 32-bit barrel shifter.
//  Sits beside the ALU. The EX-stage control stalls on req_ready/done.
//  Each cycle it shifts by at most STEP bits until the shift amount is used up.
// PARAMETERS
//  STEP   4   max bits shifted per cycle; power of two, 1..16 (elaboration error otherwise)
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   request valid; accepted when start && req_ready
//  op         in   2   00 SLL, 01 SRL, 10 ROTR, 11 SRA
//  tg         in   32  operand (target)
//  sh         in   5   shift amount (shamt)
//  req_ready  out  1   1 when state != RUN
//  busy       out  1   1 when state == RUN
//  done       out  1   one-cycle pulse: res is valid
//  res        out  32  result
// BEHAVIOUR
//  Reset: state=IDLE; res=0; done=0; busy=0; req_ready=1.
//    rst overrides all other inputs, including mid-RUN. An in-flight op is discarded with no done.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: on accept, latch op; acc<=tg; rem<=sh.
//     Go to DONE if sh==0, else go to RUN.
//   RUN: amt = (rem > STEP) ? STEP : rem; acc <= step(acc, op, amt); rem <= rem - amt.
//     Go to DONE when rem - amt == 0.
//   DONE: done=1 for exactly this cycle. Same accept rule as IDLE (back-to-back allowed).
//     With no accept, go to IDLE.
//  Latency: done asserts 1 + ceil(sh/STEP) cycles after the accept edge.
//    sh=0 -> 1 cycle. sh=31, STEP=4 -> 9 cycles.
//  start while busy: ignored, not queued. Operands are sampled only at accept.
//  res = acc. It changes during RUN.
//    It is valid and stable from the done cycle until the next accepted start.
//  Step arithmetic, per cycle, for amt in 0..STEP:
//   SLL  : zero fill from bit 0.
//   SRL  : zero fill from bit 31.
//   SRA  : fill with the current acc[31]. Sign is preserved because acc[31] never changes.
//   ROTR : bits leaving bit 0 re-enter at bit 31.
//  rem is 5-bit and never underflows (amt <= rem).
//  Composite result must equal the single-shot result: tg<<sh, tg>>sh,
//    $signed(tg)>>>sh, or a 32-bit rotate right.
// STRUCTURE
//  Shared package (alu_pkg):
//   - op encodings SH_SLL/SH_SRL/SH_ROTR/SH_SRA
//   - FSM state encodings S_IDLE/S_RUN/S_DONE
//  Sub-module shift_step (combinational): in acc[31:0], op[1:0], amt[$clog2(STEP+1)-1:0];
//    out nxt[31:0]. Bit-loop form, one mux per bit.
//  Top level: FSM, rem counter, acc register, and output decode.
// TESTING
//  1 Reset, then SLL tg=0x00000001 sh=4 -> done 2 cycles after accept; res=0x00000010.
//  2 SRA tg=0x80000000 sh=31 -> busy for 8 cycles; done at cycle 9; res=0xFFFFFFFF.
//    Also SRL with the same operands -> res=0x00000001.
//  3 ROTR tg=0x0000000F sh=4 -> res=0xF0000000.
//    SRL tg=0xF0000000 sh=0 -> done after 1 cycle; res=0xF0000000.
//  4 Hold start high through done, with a second op SLL 0xAAAAAAAA sh=3.
//    -> second op accepted in the DONE cycle; res=0x55555550; no idle gap.
//  5 start pulsed while busy (different tg) -> ignored; first result unchanged.
//    Then rst mid-RUN -> next cycle IDLE, res=0, no done pulse.
//  6 Random sweep, all ops, sh 0..31, STEP in {1,4,16}.
//    -> res matches the reference expression; latency matches formula.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared shift-op and sequencer state encodings
package alu_pkg;

   localparam logic [1:0] SH_SLL  = 2'b00;
   localparam logic [1:0] SH_SRL  = 2'b01;
   localparam logic [1:0] SH_ROTR = 2'b10;
   localparam logic [1:0] SH_SRA  = 2'b11;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

endpackage

// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result bundle between EX-stage control and the shift sequencer
interface shift_sequencer_if;
   import alu_pkg::*;

   logic        start;
   logic [1:0]  op;
   logic [31:0] tg;
   logic [4:0]  sh;
   logic        req_ready;
   logic        busy;
   logic        done;
   logic [31:0] res;

   modport master (
      output start, op, tg, sh,
      input  req_ready, busy, done, res
   );

   modport slave (
      input  start, op, tg, sh,
      output req_ready, busy, done, res
   );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-step shifter, moves acc by 0..STEP bits
module shift_step
   import alu_pkg::*;
#(
   parameter int STEP = 4,
   localparam int AW = $clog2(STEP + 1)
) (
   input  logic [31:0]   acc,
   input  logic [1:0]    op,
   input  logic [AW-1:0] amt,
   output logic [31:0]   nxt
);

   function automatic logic src_bit(input logic [31:0] a, input logic [1:0] o,
                                    input int i, input int k);
      logic b;
      case (o)
         SH_SLL:  b = (i >= k) ? a[5'(i - k)] : 1'b0;
         SH_SRL:  b = (i + k < 32) ? a[5'(i + k)] : 1'b0;
         SH_SRA:  b = (i + k < 32) ? a[5'(i + k)] : a[31];
         default: b = a[5'(i + k)];
      endcase
      return b;
   endfunction

   // Each output bit is one mux over the STEP+1 possible source bits.
   always_comb begin
      nxt = acc;
      for (int i = 0; i < 32; i++) begin
         for (int k = 1; k <= STEP; k++) begin
            if (amt == AW'(k)) begin
               nxt[i] = src_bit(acc, op, i, k);
            end
         end
      end
   end

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle SLL/SRL/ROTR/SRA unit built on a narrow step shifter
module shift_sequencer
   import alu_pkg::*;
#(
   parameter int STEP = 4
) (
   input  logic           clk,
   input  logic           rst,
   shift_sequencer_if.slave bus
);

   localparam int         AW       = $clog2(STEP + 1);
   localparam logic [4:0] STEP_REM = 5'(STEP);

   if (STEP < 1 || STEP > 16 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
      $error("shift_sequencer: STEP must be a power of two in 1..16");
   end

   logic [1:0]    state_q, state_d;
   logic [1:0]    op_q, op_d;
   logic [31:0]   acc_q, acc_d;
   logic [4:0]    rem_q, rem_d;
   logic [AW-1:0] amt;
   logic [4:0]    rem_left;
   logic [31:0]   nxt;
   logic          accept;

   shift_step #(.STEP(STEP)) u_step (
      .acc (acc_q),
      .op  (op_q),
      .amt (amt),
      .nxt (nxt)
   );

   always_comb begin
      amt      = (rem_q > STEP_REM) ? AW'(STEP) : rem_q[AW-1:0];
      rem_left = rem_q - 5'(amt);
      accept   = bus.start && (state_q != S_RUN);

      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      rem_d   = rem_q;

      case (state_q)
         S_RUN: begin
            acc_d = nxt;
            rem_d = rem_left;
            if (rem_left == 5'd0) begin
               state_d = S_DONE;
            end
         end
         // IDLE and DONE share the accept path so back-to-back ops see no gap.
         default: begin
            if (accept) begin
               op_d    = bus.op;
               acc_d   = bus.tg;
               rem_d   = bus.sh;
               state_d = (bus.sh == 5'd0) ? S_DONE : S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= SH_SLL;
         acc_q   <= 32'd0;
         rem_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
      end
   end

   assign bus.req_ready = (state_q != S_RUN);
   assign bus.busy      = (state_q == S_RUN);
   assign bus.done      = (state_q == S_DONE);
   assign bus.res       = acc_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed and swept checks of shift_sequencer at STEP 1, 4 and 16
module tb_shift_sequencer;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st  = 1'b0;
   logic [1:0]  op  = 2'b00;
   logic [31:0] tg  = 32'd0;
   logic [4:0]  sh  = 5'd0;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   shift_sequencer_if if1 ();
   shift_sequencer_if if4 ();
   shift_sequencer_if if16 ();

   assign if1.start  = st;  assign if1.op  = op;  assign if1.tg  = tg;  assign if1.sh  = sh;
   assign if4.start  = st;  assign if4.op  = op;  assign if4.tg  = tg;  assign if4.sh  = sh;
   assign if16.start = st;  assign if16.op = op;  assign if16.tg = tg;  assign if16.sh = sh;

   shift_sequencer #(.STEP(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
   shift_sequencer #(.STEP(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
   shift_sequencer #(.STEP(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

   typedef struct {
      logic [1:0]  op;
      logic [31:0] tg;
      logic [4:0]  sh;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   vec_t vecs[10];

   int          got_lat[3];
   logic [31:0] got_res[3];
   int          busy4;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] t,
                                             input logic [4:0] s);
      logic [63:0] dbl;
      dbl = {t, t} >> s;
      case (o)
         SH_SLL:  return t << s;
         SH_SRL:  return t >> s;
         SH_SRA:  return $signed(t) >>> s;
         default: return dbl[31:0];
      endcase
   endfunction

   function automatic int ref_lat(input logic [4:0] s, input int step);
      return 1 + (int'(s) + step - 1) / step;
   endfunction

   // Issue one op to all three instances and wait (bounded) for every done pulse.
   task automatic issue(input logic [1:0] o, input logic [31:0] t, input logic [4:0] s);
      logic d[3];
      logic [31:0] r[3];
      @(negedge clk);
      op = o; tg = t; sh = s; st = 1'b1;
      for (int j = 0; j < 3; j++) got_lat[j] = -1;
      busy4 = 0;
      @(negedge clk);
      st = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         d[0] = if1.done;  r[0] = if1.res;
         d[1] = if4.done;  r[1] = if4.res;
         d[2] = if16.done; r[2] = if16.res;
         if (if4.busy) busy4++;
         for (int j = 0; j < 3; j++) begin
            if (d[j] && got_lat[j] < 0) begin
               got_lat[j] = c;
               got_res[j] = r[j];
            end
         end
         if (got_lat[0] > 0 && got_lat[1] > 0 && got_lat[2] > 0) break;
         @(negedge clk);
      end
   endtask

   initial begin
      vecs[0] = '{SH_SLL,  32'h00000001, 5'd4,  32'h00000010, 2};
      vecs[1] = '{SH_SRA,  32'h80000000, 5'd31, 32'hFFFFFFFF, 9};
      vecs[2] = '{SH_SRL,  32'h80000000, 5'd31, 32'h00000001, 9};
      vecs[3] = '{SH_ROTR, 32'h0000000F, 5'd4,  32'hF0000000, 2};
      vecs[4] = '{SH_SRL,  32'hF0000000, 5'd0,  32'hF0000000, 1};
      vecs[5] = '{SH_ROTR, 32'h12345678, 5'd8,  32'h78123456, 3};
      vecs[6] = '{SH_SRA,  32'h7FFFFFF0, 5'd5,  32'h03FFFFFF, 3};
      vecs[7] = '{SH_SLL,  32'hFFFFFFFF, 5'd31, 32'h80000000, 9};
      vecs[8] = '{SH_ROTR, 32'h00000001, 5'd31, 32'h00000002, 9};
      vecs[9] = '{SH_SRA,  32'hF0000000, 5'd1,  32'hF8000000, 2};

      repeat (3) @(negedge clk);
      check("reset res",       if4.res,       32'd0);
      check("reset done",      32'(if4.done),      32'd0);
      check("reset busy",      32'(if4.busy),      32'd0);
      check("reset req_ready", 32'(if4.req_ready), 32'd1);
      rst = 1'b0;

      foreach (vecs[i]) begin
         issue(vecs[i].op, vecs[i].tg, vecs[i].sh);
         check($sformatf("vec%0d res", i),  got_res[1],      vecs[i].exp_res);
         check($sformatf("vec%0d lat", i),  32'(got_lat[1]), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d busy", i), 32'(busy4),      32'(vecs[i].exp_lat - 1));
      end

      // Start held high: second op taken in the DONE cycle of the first.
      @(negedge clk);
      op = SH_SLL; tg = 32'h00000001; sh = 5'd4; st = 1'b1;
      @(negedge clk);
      tg = 32'hAAAAAAAA; sh = 5'd3;
      check("hold run busy", 32'(if4.busy), 32'd1);
      @(negedge clk);
      check("hold first done", 32'(if4.done), 32'd1);
      check("hold first res",  if4.res,       32'h00000010);
      @(negedge clk);
      st = 1'b0;
      check("hold no gap busy", 32'(if4.busy), 32'd1);
      @(negedge clk);
      check("hold second done", 32'(if4.done), 32'd1);
      check("hold second res",  if4.res,       32'h55555550);
      repeat (40) @(negedge clk);

      // Start pulsed while busy is ignored.
      op = SH_SRL; tg = 32'hF0000000; sh = 5'd8; st = 1'b1;
      @(negedge clk);
      tg = 32'h12345678; op = SH_SLL;
      @(negedge clk);
      st = 1'b0;
      @(negedge clk);
      check("busy start done", 32'(if4.done), 32'd1);
      check("busy start res",  if4.res,       32'h00F00000);
      @(negedge clk);
      check("busy start idle",   32'(if4.done), 32'd0);
      check("busy start stable", if4.res,       32'h00F00000);
      repeat (40) @(negedge clk);

      // Reset mid-RUN discards the op without a done pulse.
      op = SH_SLL; tg = 32'h00000001; sh = 5'd12; st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      check("pre-rst busy", 32'(if4.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst res",       if4.res,            32'd0);
      check("rst busy",      32'(if4.busy),      32'd0);
      check("rst req_ready", 32'(if4.req_ready), 32'd1);
      begin
         int seen = 0;
         for (int c = 0; c < 6; c++) begin
            if (if4.done) seen++;
            @(negedge clk);
         end
         check("rst no done", 32'(seen), 32'd0);
      end

      // Swept ops against the single-shot reference at every STEP.
      for (int n = 0; n < 40; n++) begin
         logic [1:0]  ro;
         logic [31:0] rt;
         logic [4:0]  rs;
         ro = 2'($urandom_range(0, 3));
         rt = $urandom;
         rs = (n == 0) ? 5'd31 : (n == 1) ? 5'd0 : 5'($urandom_range(0, 31));
         issue(ro, rt, rs);
         check($sformatf("sweep%0d s1 res", n),  got_res[0],      ref_shift(ro, rt, rs));
         check($sformatf("sweep%0d s4 res", n),  got_res[1],      ref_shift(ro, rt, rs));
         check($sformatf("sweep%0d s16 res", n), got_res[2],      ref_shift(ro, rt, rs));
         check($sformatf("sweep%0d s1 lat", n),  32'(got_lat[0]), 32'(ref_lat(rs, 1)));
         check($sformatf("sweep%0d s4 lat", n),  32'(got_lat[1]), 32'(ref_lat(rs, 4)));
         check($sformatf("sweep%0d s16 lat", n), 32'(got_lat[2]), 32'(ref_lat(rs, 16)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
